// File: rtl/hex_load_play_pkg.sv
// Shared definitions for the hex load/play path: buffer geometry, state
// encodings and UART symbol-counter sizing helpers.
package hex_load_play_pkg;

    localparam int DEPTH  = 256;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 9;
    localparam int WIDX_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_ARMED,
        ST_PLAY,
        ST_DONE
    } play_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic int calc_sym_cnt(input int clk_freq, input int sym_rate);
        return clk_freq / sym_rate;
    endfunction

    function automatic int calc_scw(input int sym_cnt);
        return (sym_cnt > 1) ? $clog2(sym_cnt) : 1;
    endfunction

endpackage

// File: rtl/hex_load_play_acia_rx.sv
// acia_rx: 8N1 UART receiver with mid-bit sampling. The serial input is
// double-flopped here. rx_stb pulses for one clock per completed frame and
// rx_ferr qualifies that frame (stop bit sampled low).
module acia_rx
    import hex_load_play_pkg::*;
#(
    parameter int SCW     = 16,
    parameter int SYM_CNT = 40000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_ferr
);

    localparam logic [SCW-1:0] FULL_M1 = SCW'(SYM_CNT - 1);
    localparam logic [SCW-1:0] HALF_M1 = SCW'(SYM_CNT / 2 - 1);

    rx_state_t      state_q, state_d;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     dat_q, dat_d;
    logic           stb_q, stb_d;
    logic           ferr_q, ferr_d;
    logic           rx_meta_q, rx_meta_d;
    logic           rx_sync_q, rx_sync_d;

    // Frame sequencing: confirm start bit at half a symbol, then sample
    // each data bit and the stop bit one full symbol apart.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        dat_d     = dat_q;
        stb_d     = 1'b0;
        ferr_d    = ferr_q;
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        case (state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        state_d = RX_DATA;
                        cnt_d   = FULL_M1;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - SCW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - SCW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    stb_d   = 1'b1;
                    dat_d   = shift_q;
                    ferr_d  = !rx_sync_q;
                    state_d = rx_sync_q ? RX_IDLE : RX_BREAK;
                end else begin
                    cnt_d = cnt_q - SCW'(1);
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver state and synchroniser registers; the line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            dat_q     <= 8'd0;
            stb_q     <= 1'b0;
            ferr_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dat_q     <= dat_d;
            stb_q     <= stb_d;
            ferr_q    <= ferr_d;
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
        end
    end

    assign rx_dat  = dat_q;
    assign rx_stb  = stb_q;
    assign rx_ferr = ferr_q;

endmodule

// File: rtl/hex_load_play.sv
// hex_load_play: receives 256 x 16-bit words over UART (low byte first) into
// a block RAM, then replays them LSB first as a 1-bit stream on sig_out.
// Optional feature macro HEX_LOAD_PLAY_LOOP_EN: playback wraps from word 255
// to word 0 endlessly; start stops it (DONE), an rx byte starts a new load.
module hex_load_play
    import hex_load_play_pkg::*;
#(
    parameter int CLK_FREQ = 48000000,
    parameter int SYM_RATE = 1200,
    parameter int PLAY_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fpga_rx,
    input  logic start,
    output logic sig_out,
    output logic loaded,
    output logic playing,
    output logic done,
    output logic rx_err
);

    localparam int          SYM_CNT  = calc_sym_cnt(CLK_FREQ, SYM_RATE);
    localparam int          SCW      = calc_scw(SYM_CNT);
    localparam logic [15:0] DIV_LAST = 16'(PLAY_DIV - 1);
`ifdef HEX_LOAD_PLAY_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_ferr;

    acia_rx #(
        .SCW     (SCW),
        .SYM_CNT (SYM_CNT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (fpga_rx),
        .rx_dat  (rx_dat),
        .rx_stb  (rx_stb),
        .rx_ferr (rx_ferr)
    );

    play_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic [7:0]        lo_byte_q, lo_byte_d;
    logic              rx_err_q, rx_err_d;
    logic [WIDX_W-1:0] word_q, word_d;
    logic [3:0]        bit_q, bit_d;
    logic [15:0]       div_q, div_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              prime_q, prime_d;
    logic              tail_q, tail_d;
    logic              sig_out_q, sig_out_d;

    logic [WORD_W-1:0] ram_mem [DEPTH];
    logic [WORD_W-1:0] ram_rdata;
    logic              ram_we;
    logic [WIDX_W-1:0] ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WIDX_W-1:0] ram_raddr;

    logic good_byte;
    logic bad_byte;
    logic reload;

    assign good_byte = rx_stb && !rx_ferr;
    assign bad_byte  = rx_stb && rx_ferr;
    assign reload    = good_byte && ((state_q == ST_ARMED) || (state_q == ST_DONE) ||
                                     (LOOP_EN && (state_q == ST_PLAY)));

    // Load/play sequencing. The read port always points at the word after the
    // one being shifted, so the next word is ready before bit 15 ends.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        phase_d   = phase_q;
        lo_byte_d = lo_byte_q;
        rx_err_d  = rx_err_q;
        word_d    = word_q;
        bit_d     = bit_q;
        div_d     = div_q;
        shift_d   = shift_q;
        prime_d   = prime_q;
        tail_d    = tail_q;
        sig_out_d = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = addr_q[WIDX_W-1:0];
        ram_wdata = {rx_dat, lo_byte_q};
        ram_raddr = (state_q == ST_PLAY) ? word_q + 8'd1 : 8'd0;
        if (reload) begin
            state_d   = ST_LOAD;
            addr_d    = '0;
            lo_byte_d = rx_dat;
            phase_d   = 1'b1;
            rx_err_d  = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (good_byte) begin
                        if (!phase_q) begin
                            lo_byte_d = rx_dat;
                            phase_d   = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (!addr_q[ADDR_W-1]) begin
                                ram_we = 1'b1;
                                addr_d = addr_q + 9'd1;
                                if (addr_q[WIDX_W-1:0] == 8'hFF) begin
                                    state_d = ST_ARMED;
                                end
                            end
                        end
                    end else if (bad_byte) begin
                        phase_d  = 1'b0;
                        rx_err_d = 1'b1;
                    end
                end
                ST_ARMED, ST_DONE: begin
                    if (start) begin
                        state_d = ST_PLAY;
                        prime_d = 1'b1;
                        tail_d  = 1'b0;
                        word_d  = '0;
                        bit_d   = 4'd0;
                        div_d   = 16'd0;
                    end
                end
                ST_PLAY: begin
                    if (LOOP_EN && start) begin
                        state_d = ST_DONE;
                    end else if (prime_q) begin
                        shift_d = ram_rdata;
                        prime_d = 1'b0;
                    end else if (tail_q) begin
                        tail_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        sig_out_d = shift_q[0];
                        if (div_q == DIV_LAST) begin
                            div_d = 16'd0;
                            if (bit_q == 4'd15) begin
                                bit_d   = 4'd0;
                                shift_d = ram_rdata;
                                word_d  = word_q + 8'd1;
                                if ((word_q == 8'hFF) && !LOOP_EN) begin
                                    tail_d = 1'b1;
                                end
                            end else begin
                                bit_d   = bit_q + 4'd1;
                                shift_d = {1'b0, shift_q[WORD_W-1:1]};
                            end
                        end else begin
                            div_d = div_q + 16'd1;
                        end
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // Control and datapath registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            lo_byte_q <= 8'd0;
            rx_err_q  <= 1'b0;
            word_q    <= '0;
            bit_q     <= 4'd0;
            div_q     <= 16'd0;
            shift_q   <= '0;
            prime_q   <= 1'b0;
            tail_q    <= 1'b0;
            sig_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            phase_q   <= phase_d;
            lo_byte_q <= lo_byte_d;
            rx_err_q  <= rx_err_d;
            word_q    <= word_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            prime_q   <= prime_d;
            tail_q    <= tail_d;
            sig_out_q <= sig_out_d;
        end
    end

    // Single-port-per-direction block RAM with registered read (SB_RAM40_4K).
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= ram_mem[ram_raddr];
    end

    assign sig_out = sig_out_q;
    assign loaded  = (state_q != ST_LOAD);
    assign playing = (state_q == ST_PLAY);
    assign done    = (state_q == ST_DONE);
    assign rx_err  = rx_err_q;

endmodule

// File: tb/tb_hex_load_play.sv
// Directed bench for hex_load_play: two instances share the UART line and
// start pulse, one replaying at 1 clock per bit and one at 3 clocks per bit.
module tb_hex_load_play;

    localparam int SYM = 4;

    logic clk;
    logic rst_n;
    logic fpga_rx;
    logic start;
    logic sig_out_a, loaded_a, playing_a, done_a, rx_err_a;
    logic sig_out_b, loaded_b, playing_b, done_b, rx_err_b;

    int check_count = 0;
    int error_count = 0;
    logic [15:0] img [256];

    hex_load_play #(.CLK_FREQ(4), .SYM_RATE(1), .PLAY_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .fpga_rx(fpga_rx), .start(start),
        .sig_out(sig_out_a), .loaded(loaded_a), .playing(playing_a),
        .done(done_a), .rx_err(rx_err_a)
    );

    hex_load_play #(.CLK_FREQ(4), .SYM_RATE(1), .PLAY_DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .fpga_rx(fpga_rx), .start(start),
        .sig_out(sig_out_b), .loaded(loaded_b), .playing(playing_b),
        .done(done_b), .rx_err(rx_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame, LSB first; a bad stop bit is followed by one idle symbol.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_ok);
        fpga_rx = 1'b0;
        waitCycles(SYM);
        for (int i = 0; i < 8; i++) begin
            fpga_rx = data[i];
            waitCycles(SYM);
        end
        fpga_rx = stop_ok;
        waitCycles(SYM);
        if (!stop_ok) begin
            fpga_rx = 1'b1;
            waitCycles(SYM);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected stream: bit j of the image shows from negedge 3+j*div after start.
    task automatic checkPlay(input string tag, input int n, input int div,
                             input logic so, input logic pl, input logic dn);
        logic exp_play;
        logic exp_bit;
        int   idx;
`ifdef HEX_LOAD_PLAY_LOOP_EN
        exp_play = 1'b1;
`else
        exp_play = (n < 3 + 4096 * div);
`endif
        exp_bit = 1'b0;
        if (n >= 3 && exp_play) begin
            idx     = ((n - 3) / div) % 4096;
            exp_bit = img[idx / 16][idx % 16];
        end
        checkOutput({tag, "_sig_out"}, so, exp_bit);
        checkOutput({tag, "_playing"}, pl, exp_play);
        checkOutput({tag, "_done"}, dn, !exp_play);
    endtask

    initial begin
        rst_n   = 1'b0;
        fpga_rx = 1'b1;
        start   = 1'b0;
        waitCycles(3);
        checkOutput("rst_sig_out", sig_out_a, 0);
        checkOutput("rst_loaded", loaded_a, 0);
        checkOutput("rst_playing", playing_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_rx_err", rx_err_a, 0);
        rst_n = 1'b1;
        waitCycles(2);

        // Pattern upload lo=addr, hi=~addr with a framing error inside word 10.
        for (int w = 0; w < 256; w++) begin
            if (w == 10) begin
                applyStimulus(8'(w), 1'b1);
                applyStimulus(8'h55, 1'b0);
                waitCycles(3);
                checkOutput("ferr_rx_err", rx_err_a, 1);
                checkOutput("ferr_addr", dut_a.addr_q, 10);
            end
            applyStimulus(8'(w), 1'b1);
            if (w == 255) begin
                waitCycles(3);
                checkOutput("loaded_before_last", loaded_a, 0);
            end
            applyStimulus(~8'(w), 1'b1);
        end
        waitCycles(3);
        checkOutput("pattern_loaded", loaded_a, 1);
        checkOutput("pattern_rx_err_sticky", rx_err_a, 1);
        checkOutput("ram_word5", dut_a.ram_mem[5], 32'h0000FA05);
        checkOutput("ram_word10", dut_a.ram_mem[10], 32'h0000F50A);
        checkOutput("ram_word255", dut_a.ram_mem[255], 32'h000000FF);

        // Second upload: word0 = 0003, all others 0001.
        img[0] = 16'h0003;
        for (int w = 1; w < 256; w++) img[w] = 16'h0001;
        applyStimulus(img[0][7:0], 1'b1);
        waitCycles(3);
        checkOutput("reload_loaded", loaded_a, 0);
        checkOutput("reload_rx_err", rx_err_a, 0);
        pulseStart();
        waitCycles(1);
        checkOutput("start_in_load", playing_a, 0);
        applyStimulus(img[0][15:8], 1'b1);
        for (int w = 1; w < 256; w++) begin
            applyStimulus(img[w][7:0], 1'b1);
            applyStimulus(img[w][15:8], 1'b1);
        end
        waitCycles(3);
        checkOutput("upload2_loaded_a", loaded_a, 1);
        checkOutput("upload2_loaded_b", loaded_b, 1);
        checkOutput("upload2_playing", playing_a, 0);
        checkOutput("upload2_rx_err", rx_err_b, 0);

        // Replay on both instances, checked every clock.
        pulseStart();
        fork
            begin
                for (int n = 1; n <= 3 + 4096 * 3 + 1; n++) begin
                    checkPlay("a", n, 1, sig_out_a, playing_a, done_a);
                    checkPlay("b", n, 3, sig_out_b, playing_b, done_b);
                    @(negedge clk);
                end
            end
            begin
`ifndef HEX_LOAD_PLAY_LOOP_EN
                waitCycles(100);
                applyStimulus(8'hA5, 1'b1);
`endif
            end
        join

`ifdef HEX_LOAD_PLAY_LOOP_EN
        pulseStart();
        checkOutput("loop_stop_done_a", done_a, 1);
        checkOutput("loop_stop_done_b", done_b, 1);
        checkOutput("loop_stop_sig_out", sig_out_a, 0);
        checkOutput("loop_stop_playing", playing_b, 0);
`else
        checkOutput("byte_in_play_loaded", loaded_a, 1);
        checkOutput("end_sig_out_b", sig_out_b, 0);
`endif

        // Replay again from DONE, then reset asynchronously mid-play.
        pulseStart();
        checkOutput("replay_playing", playing_a, 1);
        checkOutput("replay_done_cleared", done_a, 0);
        waitCycles(2);
        checkOutput("replay_bit0", sig_out_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_sig_out_a", sig_out_a, 0);
        checkOutput("async_sig_out_b", sig_out_b, 0);
        checkOutput("async_playing", playing_a, 0);
        checkOutput("async_loaded", loaded_a, 0);
        checkOutput("async_done", done_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulseStart();
        waitCycles(2);
        checkOutput("post_rst_start_playing", playing_a, 0);
        checkOutput("post_rst_loaded", loaded_a, 0);
        checkOutput("post_rst_sig_out", sig_out_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
